// File: rtl/dmem_access_arbiter.sv
// Data-memory arbiter between the MEM-stage core port and an external loader/debug port.
// Core has priority; a starvation counter forces a bounded loader burst that stalls the core.
module dmem_access_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int LD_BURST   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_core_req,
  input  logic              i_core_we,
  input  logic [ADDR_W-1:0] i_core_addr,
  input  logic [DATA_W-1:0] i_core_wdata,
  output logic [DATA_W-1:0] o_core_rdata,
  output logic              o_core_stall,
  input  logic              i_ld_req,
  input  logic              i_ld_we,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_wdata,
  output logic              o_ld_gnt,
  output logic [DATA_W-1:0] o_ld_rdata,
  output logic              o_ld_rvalid,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_dbg_state
);

  // Loader handshake: i_ld_req is the valid and o_ld_gnt the ready; a beat transfers in the
  // cycle both are high, and the loader holds request and payload stable until that cycle.

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int BW = $clog2(LD_BURST + 1);

  typedef enum logic {
    S_CORE = 1'b0,
    S_LD   = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [SW-1:0]   r_starve_cnt;
  logic [SW-1:0]   w_starve_nxt;
  logic [BW-1:0]   r_burst_cnt;
  logic [BW-1:0]   w_burst_nxt;
  logic            w_core_own;
  logic            w_ld_gnt;
  logic            w_core_stall;
  logic            w_starve_hit;
  logic            w_burst_hit;

  assign w_starve_hit = (r_starve_cnt + SW'(1)) == SW'(STARVE_MAX);
  assign w_burst_hit  = (r_burst_cnt + BW'(1)) == BW'(LD_BURST);

  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve_cnt;
    w_burst_nxt  = r_burst_cnt;
    w_core_own   = 1'b0;
    w_ld_gnt     = 1'b0;
    w_core_stall = 1'b0;
    case (r_state)
      S_CORE: begin
        if (i_core_req) begin
          w_core_own = 1'b1;
          if (i_ld_req) begin
            if (w_starve_hit) begin
              w_state_nxt  = S_LD;
              w_starve_nxt = '0;
            end else begin
              w_starve_nxt = r_starve_cnt + SW'(1);
            end
          end else begin
            w_starve_nxt = '0;
          end
        end else begin
          // Unopposed loader is served immediately and owes nothing to the starvation count.
          w_ld_gnt     = i_ld_req;
          w_starve_nxt = '0;
        end
      end
      S_LD: begin
        w_ld_gnt     = i_ld_req;
        w_core_stall = i_core_req;
        if (i_ld_req && !w_burst_hit) begin
          w_burst_nxt = r_burst_cnt + BW'(1);
        end else begin
          w_state_nxt = S_CORE;
          w_burst_nxt = '0;
        end
      end
      default: begin
        w_state_nxt  = S_CORE;
        w_starve_nxt = '0;
        w_burst_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_core_own) begin
      o_mem_read  = ~i_core_we;
      o_mem_write = i_core_we;
      o_mem_addr  = i_core_addr;
      o_mem_wdata = i_core_wdata;
    end else if (w_ld_gnt) begin
      o_mem_read  = ~i_ld_we;
      o_mem_write = i_ld_we;
      o_mem_addr  = i_ld_addr;
      o_mem_wdata = i_ld_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_CORE;
      r_starve_cnt <= '0;
      r_burst_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_burst_cnt  <= w_burst_nxt;
    end
  end

  // Read data for a granted loader beat is captured on the following edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ld_rdata  <= '0;
      o_ld_rvalid <= 1'b0;
    end else begin
      o_ld_rvalid <= w_ld_gnt & ~i_ld_we;
      if (w_ld_gnt && !i_ld_we) begin
        o_ld_rdata <= i_mem_rdata;
      end
    end
  end

  assign o_core_rdata = i_mem_rdata;
  assign o_core_stall = w_core_stall;
  assign o_ld_gnt     = w_ld_gnt;
  assign o_dbg_state  = (r_state == S_LD);

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Randomized and directed bench for dmem_access_arbiter against a cycle-level behavioural model.
module tb_dmem_access_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int LD_BURST   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [31:0] core_addr = '0, core_wdata = '0;
  logic        ld_req = 1'b0, ld_we = 1'b0;
  logic [31:0] ld_addr = '0, ld_wdata = '0;
  logic [31:0] core_rdata, ld_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        core_stall, ld_gnt, ld_rvalid, mem_read, mem_write, dbg_state;

  logic [31:0] mem [256];
  assign mem_rdata = mem[mem_addr[7:0]];

  dmem_access_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX), .LD_BURST(LD_BURST)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_core_req(core_req), .i_core_we(core_we), .i_core_addr(core_addr),
    .i_core_wdata(core_wdata), .o_core_rdata(core_rdata), .o_core_stall(core_stall),
    .i_ld_req(ld_req), .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_wdata(ld_wdata),
    .o_ld_gnt(ld_gnt), .o_ld_rdata(ld_rdata), .o_ld_rvalid(ld_rvalid),
    .o_mem_read(mem_read), .o_mem_write(mem_write), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  bit          m_burst;
  int          m_denied;
  int          m_beats;
  bit          m_rvalid;
  logic [31:0] exp_q[$];

  // last observed values for directed checks
  logic        last_gnt, last_stall, last_mw, last_state, last_rvalid;
  logic [31:0] last_addr, last_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_burst  = 1'b0;
    m_denied = 0;
    m_beats  = 0;
    m_rvalid = 1'b0;
    exp_q.delete();
  endtask

  // driver + model step: drive at negedge, check combinational and registered outputs, advance model at posedge
  task automatic step(input logic c_req, input logic c_we, input logic [31:0] c_addr,
                      input logic [31:0] c_wdata, input logic l_req, input logic l_we,
                      input logic [31:0] l_addr, input logic [31:0] l_wdata);
    logic        e_core, e_gnt, e_stall, e_rd, e_wr;
    logic [31:0] e_addr, e_wdata;
    @(negedge clk);
    core_req = c_req; core_we = c_we; core_addr = c_addr; core_wdata = c_wdata;
    ld_req = l_req; ld_we = l_we; ld_addr = l_addr; ld_wdata = l_wdata;
    #1;
    e_core  = !m_burst && c_req;
    e_gnt   = m_burst ? l_req : (!c_req && l_req);
    e_stall = m_burst && c_req;
    e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wdata = '0;
    if (e_core) begin
      e_rd = !c_we; e_wr = c_we; e_addr = c_addr; e_wdata = c_wdata;
    end else if (e_gnt) begin
      e_rd = !l_we; e_wr = l_we; e_addr = l_addr; e_wdata = l_wdata;
    end
    chk("ld_gnt", ld_gnt, e_gnt);
    chk("core_stall", core_stall, e_stall);
    chk("mem_read", mem_read, e_rd);
    chk("mem_write", mem_write, e_wr);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("core_rdata", core_rdata, mem[e_addr[7:0]]);
    chk("state", dbg_state, m_burst);
    chk("ld_rvalid", ld_rvalid, m_rvalid);
    if (ld_rvalid) begin
      if (exp_q.size() > 0) chk("ld_rdata", ld_rdata, exp_q.pop_front());
      else chk("ld_rvalid_extra", ld_rvalid, 1'b0);
    end
    last_gnt = ld_gnt; last_stall = core_stall; last_mw = mem_write; last_state = dbg_state;
    last_addr = mem_addr; last_rvalid = ld_rvalid; last_rdata = ld_rdata;
    @(posedge clk);
    m_rvalid = e_gnt && !l_we;
    if (m_rvalid) exp_q.push_back(mem[l_addr[7:0]]);
    if (e_wr) mem[e_addr[7:0]] = e_wdata;
    if (!m_burst) begin
      if (c_req && l_req) begin
        m_denied++;
        if (m_denied == STARVE_MAX) begin
          m_burst  = 1'b1;
          m_denied = 0;
          m_beats  = 0;
        end
      end else begin
        m_denied = 0;
      end
    end else if (l_req) begin
      m_beats++;
      if (m_beats == LD_BURST) begin
        m_burst = 1'b0;
        m_beats = 0;
      end
    end else begin
      m_burst = 1'b0;
      m_beats = 0;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    bit          pend, p_we;
    logic [31:0] p_addr, p_wdata;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    model_reset();

    // reset state
    #2;
    chk("rst_state", dbg_state, 1'b0);
    chk("rst_rvalid", ld_rvalid, 1'b0);
    chk("rst_rdata", ld_rdata, 32'h0);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_gnt", ld_gnt, 1'b0);
    chk("rst_stall", core_stall, 1'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    idle();

    // 1. core-only write
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 32'h10, 32'hDEAD, 1'b0, 1'b0, '0, '0);
      chk("t1_write", last_mw, 1'b1);
      chk("t1_addr", last_addr, 32'h10);
      chk("t1_stall", last_stall, 1'b0);
    end

    // 2. loader-only read
    mem[32] = 32'h1234;
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h20, '0);
    chk("t2_gnt", last_gnt, 1'b1);
    idle();
    chk("t2_rvalid", last_rvalid, 1'b1);
    chk("t2_rdata", last_rdata, 32'h1234);
    idle();

    // 3. starvation then forced burst
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b0, 32'h4, '0, 1'b1, 1'b0, 32'(40 + i), '0);
      chk("t3_gnt", last_gnt, (i >= 4 && i < 8));
      chk("t3_stall", last_stall, (i >= 4 && i < 8));
    end
    idle(); idle();

    // 4. early burst end
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b0, 32'h8, '0, (i < 6), 1'b1, 32'(60 + i), 32'(i));
    chk("t4_state", last_state, 1'b0);
    chk("t4_stall", last_stall, 1'b0);
    for (int j = 0; j < 5; j++) begin
      step(1'b1, 1'b0, 32'h8, '0, 1'b1, 1'b0, 32'h70, '0);
      chk("t4_restart_gnt", last_gnt, (j == 4));
    end
    idle(); idle();

    // 5. reset mid-burst (second S_LD beat)
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h3, '0, 1'b1, 1'b0, 32'h50, '0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_state", dbg_state, 1'b0);
    chk("t5_stall", core_stall, 1'b0);
    chk("t5_gnt", ld_gnt, 1'b0);
    chk("t5_rvalid", ld_rvalid, 1'b0);
    chk("t5_rdata", ld_rdata, 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 32'h3, '0, 1'b0, 1'b0, '0, '0);
    chk("t5_post_stall", last_stall, 1'b0);
    idle();

    // 6. alternating core idle
    for (int i = 0; i < 12; i++) begin
      step((i % 2 == 0), 1'b0, 32'h5, '0, 1'b1, 1'b0, 32'(80 + i / 2), '0);
      chk("t6_gnt", last_gnt, (i % 2 == 1));
      chk("t6_state", last_state, 1'b0);
    end
    idle();

    // randomized traffic; loader holds its request until granted
    pend = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
    for (int i = 0; i < 600; i++) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1; p_we = $urandom_range(0, 1);
        p_addr = $urandom_range(0, 255); p_wdata = $urandom;
      end
      step(($urandom_range(0, 9) < 7), $urandom_range(0, 1), $urandom_range(0, 255), $urandom,
           pend, p_we, p_addr, p_wdata);
      if (last_gnt) pend = 1'b0;
    end
    idle(); idle();
    chk("queue_drained", exp_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
